// File: rtl/modulo_display_contador_7seg.sv
// -----------------------------------------------------------------------------
// modulo_display_contador_7seg
//
// Purpose:
//   Converts the 7-bit counter value to 3-digit BCD with an iterative
//   double-dabble FSM (9 cycles per conversion, free running).
//   Drives a time-multiplexed 3-digit common-anode 7-segment display.
//   Also exports the latched BCD result and a conversion-done strobe.
//
// Optional build macro:
//   MODULO_DISPLAY_BLANK_EN - leading-zero blanking of the tens and hundreds slots.
//
// Parameters:
//   SCAN_DIV   clk cycles per display digit slot (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   valor[6:0] in   binary value 0..127
//   bcd[11:0]  out  latched BCD {hundreds, tens, units}
//   conv_done  out  one-cycle pulse in the cycle bcd takes a new value
//   an[2:0]    out  digit enables, active-low (0 units, 1 tens, 2 hundreds)
//   seg[6:0]   out  segments, active-low, {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module modulo_display_contador_7seg #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  valor,
  output logic [11:0] bcd,
  output logic        conv_done,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  // ---------------------------------------------------------------------------
  // Double-dabble conversion
  // ---------------------------------------------------------------------------
  state_t      r_state, w_state_nxt;
  logic [6:0]  r_shift, w_shift_nxt;
  logic [11:0] r_work,  w_work_nxt;
  logic [2:0]  r_iter,  w_iter_nxt;
  logic [11:0] w_adj;
  logic        w_load;
  logic [11:0] r_bcd;
  logic        r_done;

  // Add-3 correction on every nibble that would overflow past 9 once doubled.
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < 3; i++) begin
      if (r_work[i*4 +: 4] >= 4'd5)
        w_adj[i*4 +: 4] = r_work[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_work_nxt  = r_work;
    w_iter_nxt  = r_iter;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        w_shift_nxt = valor;
        w_work_nxt  = '0;
        w_iter_nxt  = '0;
        w_state_nxt = SHIFT;
      end
      SHIFT: begin
        {w_work_nxt, w_shift_nxt} = {w_adj, r_shift} << 1;
        w_iter_nxt = r_iter + 3'd1;
        if (r_iter == 3'd6) w_state_nxt = UPDATE;
      end
      UPDATE: begin
        w_load      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_work  <= '0;
      r_iter  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_work  <= w_work_nxt;
      r_iter  <= w_iter_nxt;
    end
  end

  // bcd and the strobe change on the same edge, so the pulse marks new data.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_bcd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_load;
      if (w_load) r_bcd <= r_work;
    end
  end

  assign bcd       = r_bcd;
  assign conv_done = r_done;

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_pre;
  logic [1:0]    r_idx;
  logic [2:0]    r_an;
  logic [6:0]    r_seg;
  logic          w_tick;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [2:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;

  assign w_tick = (r_pre == PW'(SCAN_DIV - 1));

  always_comb begin
    case (r_idx)
      2'd0:    w_digit = r_bcd[3:0];
      2'd1:    w_digit = r_bcd[7:4];
      2'd2:    w_digit = r_bcd[11:8];
      default: w_digit = 4'hF;
    endcase
  end

`ifdef MODULO_DISPLAY_BLANK_EN
  // Units is never blanked, so a value of 0 still shows a single "0".
  always_comb begin
    w_blank = 1'b0;
    if (r_idx == 2'd2 && r_bcd[11:8] == 4'd0) w_blank = 1'b1;
    if (r_idx == 2'd1 && r_bcd[11:4] == 8'd0) w_blank = 1'b1;
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    case (w_digit)
      4'd0:    w_seg_nxt = 7'b1000000;
      4'd1:    w_seg_nxt = 7'b1111001;
      4'd2:    w_seg_nxt = 7'b0100100;
      4'd3:    w_seg_nxt = 7'b0110000;
      4'd4:    w_seg_nxt = 7'b0011001;
      4'd5:    w_seg_nxt = 7'b0010010;
      4'd6:    w_seg_nxt = 7'b0000010;
      4'd7:    w_seg_nxt = 7'b1111000;
      4'd8:    w_seg_nxt = 7'b0000000;
      4'd9:    w_seg_nxt = 7'b0010000;
      default: w_seg_nxt = 7'b1111111;
    endcase
    if (w_blank) w_seg_nxt = 7'b1111111;
    w_an_nxt = w_blank ? 3'b111 : ~(3'b001 << r_idx);
  end

  // r_idx names the slot shown on the next tick; an/seg are loaded together
  // from it so the enable and the pattern always belong to the same digit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pre <= '0;
      r_idx <= '0;
      r_an  <= 3'b111;
      r_seg <= 7'b1111111;
    end else if (w_tick) begin
      r_pre <= '0;
      r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_modulo_display_contador_7seg.sv
module tb_modulo_display_contador_7seg;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic [6:0]  valor = '0;
  logic [11:0] bcd;
  logic        conv_done;
  logic [2:0]  an;
  logic [6:0]  seg;

  modulo_display_contador_7seg #(.SCAN_DIV(SD)) dut (
    .clk(clk), .clr(clr), .valor(valor), .bcd(bcd),
    .conv_done(conv_done), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model (cycle-count based) ----------------
  int          m_n;      // rising edges since reset release
  int          m_samp;
  logic [11:0] m_bcd;
  logic        m_done;
  logic [2:0]  m_an;
  logic [6:0]  m_seg;

  function automatic logic [6:0] pat(input int d);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d >= 0 && d < 10) ? t[d] : 7'b1111111;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, u;
    h = 4'(v / 100); t = 4'((v / 10) % 10); u = 4'(v % 10);
    return {h, t, u};
  endfunction

  task automatic model_reset();
    m_n = 0; m_samp = 0; m_bcd = '0; m_done = 1'b0;
    m_an = 3'b111; m_seg = 7'b1111111;
  endtask

  task automatic model_edge(input int v);
    int slot, dig;
    logic blank;
    logic [2:0] one;
    m_n++;
    if (m_n % SD == 0) begin
      slot  = ((m_n / SD) - 1) % 3;
      dig   = (slot == 0) ? m_bcd[3:0] : (slot == 1) ? m_bcd[7:4] : m_bcd[11:8];
      blank = 1'b0;
`ifdef MODULO_DISPLAY_BLANK_EN
      if (slot == 2 && m_bcd[11:8] == 0) blank = 1'b1;
      if (slot == 1 && m_bcd[11:4] == 0) blank = 1'b1;
`endif
      one   = 3'b001 << slot;
      m_an  = blank ? 3'b111 : ~one;
      m_seg = blank ? 7'b1111111 : pat(dig);
    end
    m_done = 1'b0;
    if (m_n % 9 == 1) m_samp = v;
    if (m_n % 9 == 0) begin
      m_bcd  = to_bcd(m_samp);
      m_done = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("bcd", 32'(bcd), 32'(m_bcd));
    chk("conv_done", 32'(conv_done), 32'(m_done));
    chk("an", 32'(an), 32'(m_an));
    chk("seg", 32'(seg), 32'(m_seg));
  endtask

  task automatic cyc(input logic [6:0] v);
    valor = v;
    @(posedge clk);
    model_edge(int'(v));
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    model_reset();
    compare_all();
    clr = 1'b1;
  endtask

  typedef struct {
    logic [6:0]  v;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int guard;
    vecs = '{'{7'd0, 12'h000}, '{7'd5, 12'h005}, '{7'd9, 12'h009},
             '{7'd10, 12'h010}, '{7'd19, 12'h019}, '{7'd45, 12'h045},
             '{7'd64, 12'h064}, '{7'd99, 12'h099}, '{7'd100, 12'h100},
             '{7'd127, 12'h127}};

    clr = 1'b1;
    #1 clr = 1'b0;
    model_reset();
    #2 compare_all();               // asynchronous reset state
    do_reset();

    // Reset release with valor=0: display dark until first tick, strobe at edge 9.
    for (int i = 1; i <= 12; i++) begin
      cyc(7'd0);
      if (i < SD) chk("an_before_tick", 32'(an), 32'h7);
      if (i == 9) chk("first_done", 32'(conv_done), 32'd1);
    end

    // valor=127 and scanning order.
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      cyc(7'd127);
      if (i == 9)  chk("bcd127", 32'(bcd), 32'h127);
      if (i == 12) begin chk("scan_h_an", 32'(an), 32'h3); chk("scan_h_seg", 32'(seg), 32'h79); end
      if (i == 16) begin chk("scan_u_an", 32'(an), 32'h6); chk("scan_u_seg", 32'(seg), 32'h78); end
      if (i == 20) begin chk("scan_t_an", 32'(an), 32'h5); chk("scan_t_seg", 32'(seg), 32'h24); end
      if (i == 24) chk("scan_h2_an", 32'(an), 32'h3);
    end

    // Table of conversions: 18 edges of a held value guarantee a full conversion.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 18; i++) cyc(vecs[k].v);
      chk($sformatf("table_bcd_%0d", vecs[k].v), 32'(bcd), 32'(vecs[k].exp));
    end

    // valor 45 -> 99 right after the sample edge.
    guard = 0;
    do begin cyc(7'd45); guard++; end while (m_n % 9 != 1 && guard < 20);
    chk("align_45", 32'(m_n % 9), 32'd1);
    for (int i = 0; i < 8; i++) cyc(7'd99);
    chk("switch_first", 32'(bcd), 32'h045);
    chk("switch_first_done", 32'(conv_done), 32'd1);
    for (int i = 0; i < 9; i++) cyc(7'd99);
    chk("switch_second", 32'(bcd), 32'h099);

    // clr pulsed mid-SHIFT with valor=100.
    guard = 0;
    do begin cyc(7'd100); guard++; end while (m_n % 9 != 3 && guard < 20);
    #2 clr = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_an", 32'(an), 32'h7);
    chk("abort_seg", 32'(seg), 32'h7F);
    chk("abort_done", 32'(conv_done), 32'd0);
    @(posedge clk); #1;
    model_reset();
    compare_all();
    clr = 1'b1;
    for (int i = 1; i <= 9; i++) cyc(7'd100);
    chk("after_abort_bcd", 32'(bcd), 32'h100);
    chk("after_abort_done", 32'(conv_done), 32'd1);

    // valor=5: tens and hundreds slots.
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      cyc(7'd5);
`ifdef MODULO_DISPLAY_BLANK_EN
      if (i == 20) chk("blank_tens_an", 32'(an), 32'h7);
      if (i == 24) chk("blank_hund_an", 32'(an), 32'h7);
`else
      if (i == 20) begin chk("tens_an", 32'(an), 32'h5); chk("tens_seg", 32'(seg), 32'h40); end
      if (i == 24) begin chk("hund_an", 32'(an), 32'h3); chk("hund_seg", 32'(seg), 32'h40); end
`endif
      if (i == 28) begin chk("units_an", 32'(an), 32'h6); chk("units_seg", 32'(seg), 32'h12); end
    end

    // Randomized values with random hold lengths.
    do_reset();
    for (int r = 0; r < 80; r++) begin
      logic [6:0] v;
      int hold;
      v = 7'($urandom_range(0, 127));
      hold = $urandom_range(1, 14);
      for (int i = 0; i < hold; i++) cyc(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
